// File: rtl/senseye_capture_top.sv
// Senseye fabric top: on a CAPTURE edge, scans a Stonyman-style sensor, digitises
// each pixel through an SPI ADC and stores it row-major as a 16-bit word in PSRAM.
// UART / Ethernet / RS-485 pins are parked idle; the MSS side is wired elsewhere.
module senseye_capture_top #(
  parameter int ROWS      = 112,
  parameter int COLS      = 112,
  parameter int SCLK_DIV  = 2,
  parameter int PULSE_CYC = 2,
  parameter int WE_CYC    = 4
) (
  input  logic        CLK50,
  input  logic        MSS_RESET_N,
  input  logic        UART_0_RXD,
  input  logic        MAC_CRSDV,
  input  logic        MAC_RXER,
  input  logic [1:0]  MAC_RXD,
  input  logic        MAINXIN,
  input  logic        MISO,
  input  logic        CAPTURE,
  output logic        UART_0_TXD,
  output logic        MAC_MDC,
  output logic        MAC_TXEN,
  output logic [1:0]  MAC_TXD,
  inout  wire         MAC_MDIO,
  output logic        Phy_RMII_CLK,
  output logic        rs485_nre,
  output logic        rs485_de,
  output logic        incp,
  output logic        incv,
  output logic        inphi,
  output logic        resp,
  output logic        resv,
  output logic        CS,
  output logic        SCLK,
  output logic        TP_adcStartCapture,
  output logic        TP_adcConvComplete,
  output logic        psram_ncs0,
  output logic        psram_ncs1,
  output logic        psram_nwe,
  output logic        psram_noe0,
  output logic        psram_noe1,
  output logic [1:0]  psram_nbyte_en,
  output logic [24:0] psram_address,
  inout  wire  [15:0] psram_data,
  output logic [7:0]  led
);

  localparam int PW = $clog2(2*PULSE_CYC+1);
  localparam int HW = $clog2(SCLK_DIV+1);
  localparam int WW = $clog2(WE_CYC+1);
  localparam int RW = $clog2(ROWS+1);
  localparam int CW = $clog2(COLS+1);

  localparam logic [PW-1:0] P_HI   = PW'(PULSE_CYC);
  localparam logic [PW-1:0] P_LAST = PW'(2*PULSE_CYC-1);
  localparam logic [HW-1:0] H_LAST = HW'(SCLK_DIV-1);
  localparam logic [WW-1:0] W_LAST = WW'(WE_CYC-1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS-1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS-1);

  // one-hot sensor line codes, bit order {resv,resp,inphi,incv,incp}
  localparam logic [4:0] L_INCP  = 5'b00001;
  localparam logic [4:0] L_INCV  = 5'b00010;
  localparam logic [4:0] L_INPHI = 5'b00100;
  localparam logic [4:0] L_RESP  = 5'b01000;
  localparam logic [4:0] L_RESV  = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PIX_AMP, S_ADC, S_WR, S_COL_INC, S_ROW_ADV, S_DONE
  } state_t;

  typedef enum logic [1:0] {A_START, A_SHIFT, A_END} aph_t;

  state_t          state, next_state;
  aph_t            aph;
  logic [1:0]      rst_pipe;
  logic            rst_n;
  logic [2:0]      cap_sync;
  logic            cap_rise;
  logic [PW-1:0]   pcnt;
  logic [2:0]      sidx;
  logic [2:0]      seq_last;
  logic            seq_end;
  logic [4:0]      line_sel;
  logic            pulse_state;
  logic [HW-1:0]   hcnt;
  logic            sclk_lo;
  logic [4:0]      nbit;
  logic [15:0]     shreg;
  logic            adc_end;
  logic [WW-1:0]   wcnt;
  logic            wr_act;
  logic            wr_end;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [24:0]     pix_cnt;
  logic [24:0]     addr_q;
  logic [5:0]      frame_cnt;
  logic            frame_tgl;
  logic            unused_ok;

  // parked interfaces
  assign UART_0_TXD   = 1'b1;
  assign MAC_MDC      = 1'b0;
  assign MAC_TXEN     = 1'b0;
  assign MAC_TXD      = 2'b00;
  assign MAC_MDIO     = 1'bz;
  assign Phy_RMII_CLK = CLK50;
  assign rs485_nre    = 1'b1;
  assign rs485_de     = 1'b0;
  assign unused_ok    = ^{UART_0_RXD, MAC_CRSDV, MAC_RXER, MAC_RXD, MAINXIN,
                          MAC_MDIO, psram_data, shreg[15:12]};

  // reset: asserts immediately, releases two clocks after MSS_RESET_N rises
  always_ff @(posedge CLK50 or negedge MSS_RESET_N)
    if (!MSS_RESET_N) rst_pipe <= 2'b00;
    else              rst_pipe <= {rst_pipe[0], 1'b1};
  assign rst_n = rst_pipe[1];

  // CAPTURE synchroniser plus rising-edge history
  always_ff @(posedge CLK50 or negedge rst_n)
    if (!rst_n) cap_sync <= '0;
    else        cap_sync <= {cap_sync[1:0], CAPTURE};
  assign cap_rise = cap_sync[1] & ~cap_sync[2];

  // FSM state register
  always_ff @(posedge CLK50 or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;

  // pulse sequence tables and next-state logic
  always_comb begin
    next_state  = state;
    line_sel    = '0;
    seq_last    = 3'd0;
    pulse_state = 1'b0;
    unique case (state)
      S_INIT: begin
        pulse_state = 1'b1;
        seq_last    = 3'd4;
        case (sidx)
          3'd0:    line_sel = L_RESP;
          3'd1:    line_sel = L_RESV;
          3'd2:    line_sel = L_INCP;
          3'd3:    line_sel = L_RESV;
          default: line_sel = L_RESP;
        endcase
      end
      S_ROW_ADV: begin
        pulse_state = 1'b1;
        seq_last    = 3'd3;
        case (sidx)
          3'd0:    line_sel = L_RESV;
          3'd1:    line_sel = L_INCP;
          3'd2:    line_sel = L_INCV;
          default: line_sel = L_RESP;
        endcase
      end
      S_PIX_AMP: begin pulse_state = 1'b1; line_sel = L_INPHI; end
      S_COL_INC: begin pulse_state = 1'b1; line_sel = L_INCV;  end
      default: ;
    endcase
    seq_end = pulse_state && (pcnt == P_LAST) && (sidx == seq_last);
    unique case (state)
      S_IDLE:    if (cap_rise) next_state = S_INIT;
      S_INIT:    if (seq_end)  next_state = S_PIX_AMP;
      S_PIX_AMP: if (seq_end)  next_state = S_ADC;
      S_ADC:     if (adc_end)  next_state = S_WR;
      S_WR:
        if (wr_end) begin
          if (col != C_LAST)      next_state = S_COL_INC;
          else if (row != R_LAST) next_state = S_ROW_ADV;
          else                    next_state = S_DONE;
        end
      S_COL_INC: if (seq_end)  next_state = S_PIX_AMP;
      S_ROW_ADV: if (seq_end)  next_state = S_PIX_AMP;
      S_DONE:                  next_state = S_IDLE;
      default:                 next_state = S_IDLE;
    endcase
  end

  // sensor lines: high for the first PULSE_CYC clocks of each pulse slot
  assign {resv, resp, inphi, incv, incp} = (pcnt < P_HI) ? line_sel : 5'b00000;

  // pulse slot counter and index into the current sequence
  always_ff @(posedge CLK50 or negedge rst_n)
    if (!rst_n) begin
      pcnt <= '0;
      sidx <= '0;
    end else if (next_state != state || !pulse_state) begin
      pcnt <= '0;
      sidx <= '0;
    end else if (pcnt == P_LAST) begin
      pcnt <= '0;
      sidx <= sidx + 3'd1;
    end else begin
      pcnt <= pcnt + PW'(1);
    end

  // SPI conversion: start clock, 16 SCLK periods, one clock of SCLK high, then CS up
  always_ff @(posedge CLK50 or negedge rst_n)
    if (!rst_n) begin
      aph     <= A_START;
      hcnt    <= '0;
      sclk_lo <= 1'b0;
      nbit    <= '0;
      shreg   <= '0;
    end else if (state != S_ADC) begin
      aph     <= A_START;
      hcnt    <= '0;
      sclk_lo <= 1'b0;
      nbit    <= '0;
    end else begin
      case (aph)
        A_START: begin
          aph     <= A_SHIFT;
          sclk_lo <= 1'b1;
          hcnt    <= '0;
        end
        A_SHIFT:
          if (nbit == 5'd16) aph <= A_END;
          else if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (sclk_lo) begin
              // SCLK rises on this edge; MISO has been stable since the fall
              sclk_lo <= 1'b0;
              shreg   <= {shreg[14:0], MISO};
              nbit    <= nbit + 5'd1;
            end else begin
              sclk_lo <= 1'b1;
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        default: ;
      endcase
    end

  assign adc_end            = (state == S_ADC) && (aph == A_END);
  assign CS                 = !((state == S_ADC) && (aph != A_END));
  assign SCLK               = !((state == S_ADC) && (aph == A_SHIFT) && sclk_lo);
  assign TP_adcStartCapture = (state == S_ADC) && (aph == A_START);
  assign TP_adcConvComplete = adc_end;

  // write-strobe length counter
  always_ff @(posedge CLK50 or negedge rst_n)
    if (!rst_n)              wcnt <= '0;
    else if (state != S_WR)  wcnt <= '0;
    else                     wcnt <= wcnt + WW'(1);
  assign wr_end = (state == S_WR) && (wcnt == W_LAST);

  // pixel position; address latched before the write so it is stable throughout
  always_ff @(posedge CLK50 or negedge rst_n)
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      pix_cnt <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          row     <= '0;
          col     <= '0;
          pix_cnt <= '0;
        end
        S_ADC:     if (adc_end) addr_q  <= pix_cnt;
        S_WR:      if (wr_end)  pix_cnt <= pix_cnt + 25'd1;
        S_COL_INC: if (seq_end) col     <= col + CW'(1);
        S_ROW_ADV:
          if (seq_end) begin
            col <= '0;
            row <= row + RW'(1);
          end
        default: ;
      endcase
    end

  assign wr_act         = (state == S_WR);
  assign psram_address  = addr_q;
  assign psram_ncs0     = !wr_act;
  assign psram_nwe      = !wr_act;
  assign psram_nbyte_en = wr_act ? 2'b00 : 2'b11;
  assign psram_data     = wr_act ? {4'b0000, shreg[11:0]} : 16'bz;
  assign psram_ncs1     = 1'b1;
  assign psram_noe0     = 1'b1;
  assign psram_noe1     = 1'b1;

  // completed-frame bookkeeping
  always_ff @(posedge CLK50 or negedge rst_n)
    if (!rst_n) begin
      frame_cnt <= '0;
      frame_tgl <= 1'b0;
    end else if (state == S_DONE) begin
      frame_cnt <= frame_cnt + 6'd1;
      frame_tgl <= ~frame_tgl;
    end

  assign led = {frame_cnt, frame_tgl, state != S_IDLE};

endmodule

// File: tb/tb_senseye_capture_top.sv
// Bench for senseye_capture_top on a 2x3 frame: an SPI ADC model serves words,
// monitors collect pulses, CS windows and PSRAM writes, and each frame is
// compared against what the sensor/ADC/PSRAM rules predict.
module tb_senseye_capture_top;
  localparam int R = 2, C = 3, P = 2, D = 2, W = 4;

  logic clk = 1'b0, rst_n = 1'b0, capture = 1'b0, miso = 1'b0;
  logic uart_rxd = 1'b0, crsdv = 1'b0, rxer = 1'b0, mainxin = 1'b0;
  logic [1:0] rxd = 2'b00;
  wire mdio;
  wire [15:0] pdata;
  logic uart_txd, mdc, txen, rmii_clk, nre, de;
  logic [1:0] txd, nbe;
  logic incp, incv, inphi, resp, resv, cs, sclk, tp_s, tp_c;
  logic ncs0, ncs1, nwe, noe0, noe1;
  logic [24:0] addr;
  logic [7:0] led;

  int checks = 0, failures = 0;

  always #10 clk = ~clk;

  senseye_capture_top #(.ROWS(R), .COLS(C), .SCLK_DIV(D), .PULSE_CYC(P), .WE_CYC(W)) dut (
    .CLK50(clk), .MSS_RESET_N(rst_n), .UART_0_RXD(uart_rxd), .MAC_CRSDV(crsdv),
    .MAC_RXER(rxer), .MAC_RXD(rxd), .MAINXIN(mainxin), .MISO(miso), .CAPTURE(capture),
    .UART_0_TXD(uart_txd), .MAC_MDC(mdc), .MAC_TXEN(txen), .MAC_TXD(txd), .MAC_MDIO(mdio),
    .Phy_RMII_CLK(rmii_clk), .rs485_nre(nre), .rs485_de(de),
    .incp(incp), .incv(incv), .inphi(inphi), .resp(resp), .resv(resv),
    .CS(cs), .SCLK(sclk), .TP_adcStartCapture(tp_s), .TP_adcConvComplete(tp_c),
    .psram_ncs0(ncs0), .psram_ncs1(ncs1), .psram_nwe(nwe), .psram_noe0(noe0),
    .psram_noe1(noe1), .psram_nbyte_en(nbe), .psram_address(addr), .psram_data(pdata),
    .led(led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- SPI ADC model (mode 3: shift out on SCLK fall, MSB first)
  int miso_mode = 0;  // 0 random word, 1 word 0ABC, 2 MISO held high
  logic [15:0] word;
  int bidx = -1;
  logic [15:0] served_q[$];
  int windows = 0, bad_windows = 0, rises = 0;

  always @(negedge cs) begin
    case (miso_mode)
      0:       word = 16'($urandom);
      1:       word = 16'h0ABC;
      default: word = 16'hFFFF;
    endcase
    served_q.push_back(word);
    bidx  = 15;
    rises = 0;
  end

  always @(negedge sclk)
    if (!cs && bidx >= 0) begin
      miso = (miso_mode == 2) ? 1'b1 : word[bidx];
      bidx--;
    end

  always @(posedge sclk) if (!cs) rises++;

  always @(posedge cs) begin
    windows++;
    if (rises != 16) bad_windows++;
  end

  // ---------------- sensor pulse monitor
  int pcount[5] = '{default: 0};
  int run[5] = '{default: 0};
  logic [4:0] prev_l = 5'b0, cur_l;
  int overlap = 0, lines_in_adc = 0, badw = 0, badgap = 0, lowrun = 1000;
  int tps = 0, tpc = 0, busy_cyc = 0;

  always @(negedge clk) begin
    cur_l = {resv, resp, inphi, incv, incp};
    if ($countones(cur_l) > 1) overlap++;
    if (!cs && cur_l != 5'b0) lines_in_adc++;
    if (tp_s) tps++;
    if (tp_c) tpc++;
    if (led[0]) busy_cyc++;
    if ((cur_l & ~prev_l) != 5'b0 && lowrun < P) badgap++;
    for (int i = 0; i < 5; i++) begin
      if (cur_l[i]) begin
        if (!prev_l[i]) pcount[i]++;
        run[i]++;
      end else if (prev_l[i]) begin
        if (run[i] != P) badw++;
        run[i] = 0;
      end
    end
    if (cur_l == 5'b0) lowrun++; else lowrun = 0;
    prev_l = cur_l;
  end

  // ---------------- PSRAM write monitor
  typedef struct {
    logic [24:0] a;
    logic [15:0] d;
    int          w;
    bit          ok;
  } wr_t;
  wr_t wr_q[$];
  wr_t cur;
  logic prev_nwe = 1'b1;

  always @(negedge clk) begin
    if (!nwe && prev_nwe) begin
      cur.a  = addr;
      cur.d  = pdata;
      cur.w  = 1;
      cur.ok = !ncs0 && nbe == 2'b00 && noe0 && noe1 && ncs1;
    end else if (!nwe) begin
      cur.w++;
      if (addr != cur.a || pdata != cur.d || ncs0 || nbe != 2'b00) cur.ok = 1'b0;
    end else if (!prev_nwe) begin
      if (!ncs0 || nbe != 2'b11) cur.ok = 1'b0;
      wr_q.push_back(cur);
    end
    prev_nwe = nwe;
  end

  // ---------------- helpers
  task automatic clear_mon();
    wr_q.delete();
    served_q.delete();
    windows = 0; bad_windows = 0; overlap = 0; lines_in_adc = 0;
    badw = 0; badgap = 0; tps = 0; tpc = 0; busy_cyc = 0;
    for (int i = 0; i < 5; i++) pcount[i] = 0;
  endtask

  task automatic pulse_capture();
    @(posedge clk); #3 capture = 1'b1;
    repeat (4) @(posedge clk);
    #3 capture = 1'b0;
  endtask

  task automatic wait_led0(input logic lvl, input string tag);
    int n;
    n = 0;
    while (led[0] !== lvl && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(led[0]), 32'(lvl));
  endtask

  task automatic check_frame(input string tag, input int mode, input logic [7:0] exp_led);
    logic [15:0] exp_d;
    check({tag, ".windows"}, windows, R*C);
    check({tag, ".sclk16"}, bad_windows, 0);
    check({tag, ".tpstart"}, tps, R*C);
    check({tag, ".tpdone"}, tpc, R*C);
    check({tag, ".writes"}, wr_q.size(), R*C);
    for (int k = 0; k < wr_q.size(); k++) begin
      if (mode == 1)      exp_d = 16'h0ABC;
      else if (mode == 2) exp_d = 16'h0FFF;
      else if (k < served_q.size()) exp_d = {4'h0, served_q[k][11:0]};
      else                exp_d = 16'hDEAD;
      check($sformatf("%s.addr%0d", tag, k), 32'(wr_q[k].a), k);
      check($sformatf("%s.data%0d", tag, k), 32'(wr_q[k].d), 32'(exp_d));
      check($sformatf("%s.we_len%0d", tag, k), wr_q[k].w, W);
      check($sformatf("%s.strobes%0d", tag, k), 32'(wr_q[k].ok), 1);
    end
    check({tag, ".inphi"}, pcount[2], R*C);
    check({tag, ".incv"},  pcount[1], R*(C-1) + (R-1));
    check({tag, ".incp"},  pcount[0], 1 + (R-1));
    check({tag, ".resp"},  pcount[3], 2 + (R-1));
    check({tag, ".resv"},  pcount[4], 2 + (R-1));
    check({tag, ".overlap"}, overlap, 0);
    check({tag, ".lines_in_adc"}, lines_in_adc, 0);
    check({tag, ".pulse_width"}, badw, 0);
    check({tag, ".pulse_gap"}, badgap, 0);
    check({tag, ".led"}, 32'(led), 32'(exp_led));
    check({tag, ".idle_bus"}, 32'({cs, sclk, nwe, ncs0, nbe}), 32'(6'b111111));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cs_sclk"}, 32'({cs, sclk}), 32'(2'b11));
    check({tag, ".lines"}, 32'({resv, resp, inphi, incv, incp}), 0);
    check({tag, ".psram_n"}, 32'({ncs0, ncs1, nwe, noe0, noe1}), 32'(5'b11111));
    check({tag, ".nbyte"}, 32'(nbe), 32'(2'b11));
    check({tag, ".addr"}, 32'(addr), 0);
    check({tag, ".led"}, 32'(led), 0);
    check({tag, ".tp"}, 32'({tp_s, tp_c}), 0);
  endtask

  // ---------------- directed sequence
  int f1_len, falls, n;
  logic pn;

  initial begin
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("idle");
    check("idle.uart", 32'(uart_txd), 1);
    check("idle.mac", 32'({mdc, txen, txd}), 0);
    check("idle.rs485", 32'({nre, de}), 32'(2'b10));
    check("idle.rmii_clk", 32'(rmii_clk), 32'(clk));
    check("idle.no_writes", wr_q.size(), 0);

    // frame 1: random ADC words
    @(posedge clk); #1 clear_mon();
    miso_mode = 0;
    pulse_capture();
    wait_led0(1'b1, "f1.busy");
    wait_led0(1'b0, "f1.end");
    f1_len = busy_cyc;
    check_frame("f1", 0, 8'b00000110);

    // frame 2: fixed word, CAPTURE re-pulsed mid-frame must be ignored
    @(posedge clk); #1 clear_mon();
    miso_mode = 1;
    pulse_capture();
    wait_led0(1'b1, "f2.busy");
    repeat (100) @(posedge clk);
    pulse_capture();
    wait_led0(1'b0, "f2.end");
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("f2.stays_idle", 32'(led[0]), 0);
    check("f2.frame_len", busy_cyc, f1_len);
    check_frame("f2", 1, 8'b00001000);

    // frame 3: MISO held high
    @(posedge clk); #1 clear_mon();
    miso_mode = 2;
    pulse_capture();
    wait_led0(1'b1, "f3.busy");
    wait_led0(1'b0, "f3.end");
    check("f3.frame_len", busy_cyc, f1_len);
    check_frame("f3", 2, 8'b00001110);

    // reset during the third write
    @(posedge clk); #1 clear_mon();
    miso_mode = 0;
    pulse_capture();
    falls = 0; n = 0; pn = 1'b1;
    while (falls < 3 && n < 20000) begin
      @(negedge clk);
      n++;
      if (!nwe && pn) falls++;
      pn = nwe;
    end
    check("rst.reach_write3", falls, 3);
    @(negedge clk);
    check("rst.in_write", 32'(nwe), 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 clear_mon();
    @(negedge clk);
    check("rst.no_restart", 32'(led), 0);

    // frame after reset restarts at address 0 with a fresh counter
    pulse_capture();
    wait_led0(1'b1, "f4.busy");
    wait_led0(1'b0, "f4.end");
    check_frame("f4", 0, 8'b00000110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
